fmc_timer_tx: RTL and testbench
===============================

# fmc_timer_tx

Transmit end of the FMC timing link. The block keeps the master time (a 40-bit UTC seconds counter and a 28-bit 8 ns tick counter) and emits one serial frame on `fmc_tm_serial` at every second boundary. Each frame carries a start bit (the PPS marker), one guard bit and the 40-bit UTC of the second just begun. The block sits on the timing-master board and drives the FMC line consumed by the downstream timing receivers.

## Interface
- `CYCLES_PER_SEC`, default 125000000: ticks per second. Must be ≥ 64 and ≤ 2^28.
- `PPS_WIDTH`, default 500: pps_o high time in ticks. Must satisfy 1 ≤ PPS_WIDTH < CYCLES_PER_SEC.
- `fmc_clk` input 1: the single clock (8 ns). All logic is on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `enable` input 1: frame transmission enable. Sampled only at a frame start.
- `utc_load` input 1: one-cycle strobe that loads `utc_load_value` into the UTC counter.
- `utc_load_value` input 40: new UTC seconds value.
- `fmc_tm_serial` output 1: serial timing line, registered.
- `pps_o` output 1: local PPS, registered.
- `timer_utc` output 40: current UTC seconds.
- `timer_8ns` output 28: tick within the second, range 0..CYCLES_PER_SEC-1.
- `tx_busy` output 1: high while a frame is on the line.
- `frame_done` output 1: one-cycle pulse after the last data bit.

## Operation
- **Reset** (synchronous, `rst`=1 at an edge) takes effect at the next edge. All outputs go to 0: `timer_utc`, `timer_8ns`, `fmc_tm_serial`, `pps_o`, `tx_busy`, `frame_done`. The FSM goes to IDLE, `running`=0 and the shadow register clears.
- **Reset mid-frame** aborts the frame. The line is 0 from the next cycle.
- **Tick counter:** `timer_8ns` increments by 1 each cycle. At CYCLES_PER_SEC-1 it wraps to 0 (the "wrap edge").
- **UTC counter:**
  - On the wrap edge `timer_utc` increments by 1, modulo 2^40; 0xFF_FFFF_FFFF wraps to 0.
  - `utc_load` loads `utc_load_value` at the next edge and does not touch `timer_8ns`.
  - If `utc_load` coincides with the wrap edge, the load wins and no increment occurs.
- **Running flag:** `running` is set on the first wrap edge after reset and cleared only by reset.
- **pps_o:** high exactly in cycles where `running`=1 and `timer_8ns` < PPS_WIDTH. It is therefore low during the first partial second after reset.
- **FSM states:** IDLE, START, GUARD, DATA. A 6-bit bit counter is used in DATA.
  - **IDLE:** line 0. On the wrap edge with `enable`=1:
    - go to START;
    - shadow ← the value `timer_utc` takes at that edge (incremented value or load value).
  - With `enable`=0 at the wrap edge, stay in IDLE; no frame is sent that second.
  - **START:** line 1, one cycle. Next state GUARD.
  - **GUARD:** line 0, one cycle. Next state DATA, bit counter ← 0.
  - **DATA:** line = shadow[39 − count], i.e. MSB first, for 40 cycles. After count 39, go to IDLE and pulse `frame_done` in that first IDLE cycle.
- **Frame contents are frozen at start.** A `utc_load` during a frame changes `timer_utc` immediately but is carried only by the next frame. Dropping `enable` mid-frame does not truncate the frame.
- **tx_busy** is high in the START, GUARD and DATA states.

## Timing
- Frame layout relative to the cycle where `timer_8ns`=0 (cycle 0):
  - cycle 0: start bit = 1, coincident with the first `pps_o`-high cycle;
  - cycle 1: guard = 0;
  - cycles 2..41: UTC[39]..UTC[0];
  - cycle 42: `frame_done`=1;
  - cycles 42..CYCLES_PER_SEC-1: line 0.
- The frame is 42 cycles long. The line stays 0 for at least CYCLES_PER_SEC-42 (≥ 22) cycles before the next start bit. This quiet gap gives the receiver time to return to idle.
- The UTC carried in a frame equals `timer_utc` during cycles 0..41, absent loads.
- `utc_load` latency: `timer_utc` shows the new value one cycle after the strobe.
- No frame starts in the cycle immediately after reset release. The first frame starts CYCLES_PER_SEC cycles after release, and its UTC is 1 if no load occurred.

## Test plan
All scenarios use CYCLES_PER_SEC=100 and PPS_WIDTH=5.

1. **Reset, then free run with `enable`=1.**
   - First frame at cycle 100 after release: line 1, 0, then 40 bits encoding 1.
   - `pps_o` high in cycles 100..104 only.
   - `frame_done` at cycle 142.
2. **Load during IDLE.** `utc_load` with 0x12_3456_789A at `timer_8ns`=50.
   - `timer_utc`=0x12_3456_789A at tick 51.
   - The next frame carries 0x12_3456_789B, MSB first.
3. **Load coincident with the wrap edge.** Load value 0x00_0000_0010.
   - `timer_utc`=0x10, not incremented.
   - The frame carries 0x10.
4. **Load mid-frame.** Load 0x55 at tick 20 of a frame carrying 7.
   - The frame still carries 7.
   - The next frame carries 0x56.
5. **Enable behaviour.**
   - `enable`=0 over a wrap edge: no start bit, `tx_busy` stays 0, the counters keep running.
   - `enable` dropped at tick 10: the frame completes all 42 cycles.
6. **UTC rollover and reset mid-frame.**
   - Load 0xFF_FFFF_FFFF, then wrap: `timer_utc`=0 and the frame carries all zeros.
   - Separately, `rst` asserted at tick 20 of a frame: the line and all outputs are 0 from the next cycle.

Source files
------------

// File: rtl/fmc_timer_tx.sv
// FMC timing-link transmitter: keeps master UTC seconds and 8 ns ticks, and
// sends a start/guard/40-bit-UTC frame on fmc_tm_serial at every second boundary.
//
// state | meaning
// IDLE  | line low, waiting for a wrap edge with enable high
// START | start bit (line high), coincident with the first pps_o cycle
// GUARD | guard bit (line low)
// DATA  | 40 UTC bits, MSB first, shifted out of the frozen shadow word
module fmc_timer_tx #(
  parameter int unsigned CYCLES_PER_SEC = 125000000,
  parameter int unsigned PPS_WIDTH      = 500
) (
  input  logic        fmc_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        utc_load,
  input  logic [39:0] utc_load_value,
  output logic        fmc_tm_serial,
  output logic        pps_o,
  output logic [39:0] timer_utc,
  output logic [27:0] timer_8ns,
  output logic        tx_busy,
  output logic        frame_done
);

  localparam logic [27:0] TICK_MAX = 28'(CYCLES_PER_SEC - 1);
  localparam logic [27:0] PPS_W    = 28'(PPS_WIDTH);
  localparam logic [5:0]  LAST_BIT = 6'd39;

  typedef enum logic [1:0] {IDLE, START, GUARD, DATA} state_t;

  state_t      state;
  logic        running;
  logic [39:0] shadow;
  logic [5:0]  bit_cnt;

  logic        wrap;
  logic [27:0] tick_next;
  logic [39:0] utc_next;

  // A load on the wrap edge replaces the increment rather than adding to it.
  always_comb begin
    wrap      = (timer_8ns == TICK_MAX);
    tick_next = wrap ? 28'd0 : timer_8ns + 28'd1;
    if (utc_load) begin
      utc_next = utc_load_value;
    end else if (wrap) begin
      utc_next = timer_utc + 40'd1;
    end else begin
      utc_next = timer_utc;
    end
  end

  always_ff @(posedge fmc_clk) begin
    if (rst) begin
      state         <= IDLE;
      running       <= 1'b0;
      shadow        <= '0;
      bit_cnt       <= '0;
      timer_8ns     <= '0;
      timer_utc     <= '0;
      fmc_tm_serial <= 1'b0;
      pps_o         <= 1'b0;
      tx_busy       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      timer_8ns  <= tick_next;
      timer_utc  <= utc_next;
      frame_done <= 1'b0;
      if (wrap) begin
        running <= 1'b1;
      end
      // pps follows the next-cycle tick so it lines up with the start bit.
      pps_o <= (running || wrap) && (tick_next < PPS_W);

      case (state)
        IDLE: begin
          fmc_tm_serial <= 1'b0;
          if (wrap && enable) begin
            state         <= START;
            shadow        <= utc_next;
            fmc_tm_serial <= 1'b1;
            tx_busy       <= 1'b1;
          end
        end
        START: begin
          state         <= GUARD;
          fmc_tm_serial <= 1'b0;
        end
        GUARD: begin
          state         <= DATA;
          bit_cnt       <= '0;
          fmc_tm_serial <= shadow[39];
          shadow        <= {shadow[38:0], 1'b0};
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state         <= IDLE;
            fmc_tm_serial <= 1'b0;
            tx_busy       <= 1'b0;
            frame_done    <= 1'b1;
          end else begin
            bit_cnt       <= bit_cnt + 6'd1;
            fmc_tm_serial <= shadow[39];
            shadow        <= {shadow[38:0], 1'b0};
          end
        end
        default: begin
          state         <= IDLE;
          fmc_tm_serial <= 1'b0;
          tx_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_timer_tx.sv
// Bench for fmc_timer_tx: directed scenarios plus random traffic against a
// position-in-second reference model and an independent frame deserializer.
module tb_fmc_timer_tx;

  localparam int C  = 100;
  localparam int PW = 5;

  logic        fmc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        utc_load = 1'b0;
  logic [39:0] utc_load_value = '0;
  logic        fmc_tm_serial;
  logic        pps_o;
  logic [39:0] timer_utc;
  logic [27:0] timer_8ns;
  logic        tx_busy;
  logic        frame_done;

  fmc_timer_tx #(.CYCLES_PER_SEC(C), .PPS_WIDTH(PW)) dut (
    .fmc_clk(fmc_clk),
    .rst(rst),
    .enable(enable),
    .utc_load(utc_load),
    .utc_load_value(utc_load_value),
    .fmc_tm_serial(fmc_tm_serial),
    .pps_o(pps_o),
    .timer_utc(timer_utc),
    .timer_8ns(timer_8ns),
    .tx_busy(tx_busy),
    .frame_done(frame_done)
  );

  always #4 fmc_clk = ~fmc_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: time of day, and whether a frame began this second.
  int          m_tick = 0;
  logic [39:0] m_utc = '0;
  bit          m_run = 1'b0;
  bit          m_fa = 1'b0;
  logic [39:0] m_fval = '0;

  // Receiver-side deserializer, independent of the model.
  int          rx_phase = 0;
  int          rx_cnt = 0;
  logic [39:0] rx_word = '0;
  logic [39:0] rx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          wrap;
    logic        e_ser;
    logic [39:0] e_next;
    @(posedge fmc_clk);
    if (rst) begin
      m_tick = 0;
      m_utc  = '0;
      m_run  = 1'b0;
      m_fa   = 1'b0;
    end else begin
      wrap   = (m_tick == C - 1);
      e_next = utc_load ? utc_load_value : (wrap ? m_utc + 40'd1 : m_utc);
      if (wrap) begin
        m_run = 1'b1;
        m_fa  = enable;
        if (enable) m_fval = e_next;
      end
      m_utc  = e_next;
      m_tick = wrap ? 0 : m_tick + 1;
    end
    #1;
    e_ser = 1'b0;
    if (m_fa) begin
      if (m_tick == 0) e_ser = 1'b1;
      else if (m_tick >= 2 && m_tick <= 41) e_ser = m_fval[41 - m_tick];
    end
    chk("timer_8ns", 64'(timer_8ns), 64'(m_tick));
    chk("timer_utc", 64'(timer_utc), 64'(m_utc));
    chk("pps_o", 64'(pps_o), 64'(m_run && m_tick < PW));
    chk("serial", 64'(fmc_tm_serial), 64'(e_ser));
    chk("tx_busy", 64'(tx_busy), 64'(m_fa && m_tick <= 41));
    chk("frame_done", 64'(frame_done), 64'(m_fa && m_tick == 42));
    if (rst) begin
      rx_phase = 0;
    end else begin
      case (rx_phase)
        0: if (fmc_tm_serial === 1'b1) rx_phase = 1;
        1: begin rx_phase = 2; rx_cnt = 0; end
        default: begin
          rx_word = {rx_word[38:0], fmc_tm_serial};
          rx_cnt++;
          if (rx_cnt == 40) begin
            rx_q.push_back(rx_word);
            rx_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_tick(input int t);
    int guard = 0;
    while (m_tick != t && guard < 300) begin
      step();
      guard++;
    end
    if (m_tick != t) begin
      n_fail++;
      $error("FAIL run_to_tick: got tick %0d expected %0d", m_tick, t);
    end
  endtask

  task automatic chk_rx(input string tag, input logic [39:0] exp);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) chk(tag, 64'(rx_q.pop_front()), 64'(exp));
    rx_q.delete();
  endtask

  task automatic load_now(input logic [39:0] v);
    utc_load = 1'b1;
    utc_load_value = v;
    step();
    utc_load = 1'b0;
  endtask

  initial begin
    // 1: reset, then free run
    rst = 1'b1; enable = 1'b1;
    run(3);
    chk("rst_tick", 64'(timer_8ns), 64'd0);
    chk("rst_utc", 64'(timer_utc), 64'd0);
    rst = 1'b0;
    run(100);
    chk("s1_start", 64'(fmc_tm_serial), 64'd1);
    chk("s1_pps", 64'(pps_o), 64'd1);
    chk("s1_utc", 64'(timer_utc), 64'd1);
    run(42);
    chk("s1_done", 64'(frame_done), 64'd1);
    chk_rx("s1_frame", 40'd1);

    // 2: load during idle
    run_to_tick(50);
    load_now(40'h12_3456_789A);
    chk("s2_utc", 64'(timer_utc), 64'h12_3456_789A);
    chk("s2_tick", 64'(timer_8ns), 64'd51);
    run_to_tick(C - 1);
    run(43);
    chk_rx("s2_frame", 40'h12_3456_789B);

    // 3: load on the wrap edge
    run_to_tick(C - 1);
    load_now(40'h10);
    chk("s3_utc", 64'(timer_utc), 64'h10);
    run(42);
    chk_rx("s3_frame", 40'h10);

    // 4: load mid-frame
    run_to_tick(50);
    load_now(40'd6);
    run_to_tick(C - 1);
    step();
    run_to_tick(20);
    load_now(40'h55);
    chk("s4_utc", 64'(timer_utc), 64'h55);
    run_to_tick(50);
    chk_rx("s4_frame_a", 40'd7);
    run_to_tick(C - 1);
    run(43);
    chk_rx("s4_frame_b", 40'h56);

    // 5: enable low over a wrap, then dropped mid-frame
    enable = 1'b0;
    run_to_tick(C - 1);
    step();
    chk("s5_busy", 64'(tx_busy), 64'd0);
    chk("s5_line", 64'(fmc_tm_serial), 64'd0);
    chk("s5_utc", 64'(timer_utc), 64'h57);
    run(50);
    chk("s5_noframe", 64'(rx_q.size()), 64'd0);
    enable = 1'b1;
    run_to_tick(C - 1);
    step();
    run_to_tick(10);
    enable = 1'b0;
    run_to_tick(50);
    chk_rx("s5_frame", 40'h58);
    enable = 1'b1;

    // 6: UTC rollover, then reset mid-frame
    run_to_tick(50);
    load_now(40'hFF_FFFF_FFFF);
    run_to_tick(C - 1);
    step();
    chk("s6_utc_wrap", 64'(timer_utc), 64'd0);
    run(42);
    chk_rx("s6_frame", 40'd0);
    run_to_tick(C - 1);
    step();
    run_to_tick(20);
    rst = 1'b1;
    step();
    chk("s6_rst_line", 64'(fmc_tm_serial), 64'd0);
    chk("s6_rst_busy", 64'(tx_busy), 64'd0);
    chk("s6_rst_utc", 64'(timer_utc), 64'd0);
    rst = 1'b0;
    run(5);
    rx_q.delete();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      utc_load = ($urandom_range(0, 39) == 0) ||
                 (m_tick == C - 1 && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        utc_load_value = 40'hFF_FFFF_FFFF - 40'($urandom_range(0, 2));
      else
        utc_load_value = {8'($urandom_range(0, 255)), 32'($urandom())};
      step();
    end
    rst = 1'b0;
    utc_load = 1'b0;
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
